reaction_game_ctrl: RTL and testbench
=====================================

# reaction_game_ctrl

Parametrised next-generation controller for the reaction-time game. It drives `NUM_CH` LED/key channel pairs and lights one random channel after a random off delay. It scores hits, misses, wrong keys and early presses, and shrinks the response window linearly as the score rises. It sits between the key edge detectors, the shared `rnd` LFSR and the score display/LED drivers.

## Interface
Parameters:
- `NUM_CH`, 2 — number of LED/key channels (2..16).
- `SCORE_MAX`, 99 — score saturation ceiling (≤255).
- `RAMP_SCORE`, 33 — score at which the window reaches `MIN_ACTIVE` (≥1).
- `MIN_ACTIVE`, 15000000 — shortest response window, in cycles.
- `MAX_ACTIVE`, 75000000 — window at score 0, in cycles (> `MIN_ACTIVE`).
- `OFF_BASE`, 12500000 — base off delay, in cycles.
- `RESULT_CYCLES`, 25000000 — length of the result display, in cycles.
- `FLASH_HALF`, 2500000 — half-period of the miss flash, in cycles.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` input 1 — system clock.
- `rst` input 1 — asynchronous active-high reset.
- `run_enable` input 1 — game running; low synchronously forces IDLE and clears `score`.
- `rnd` input 32 — free-running random word.
- `key_edge` input `NUM_CH` — one-cycle press pulses, one per channel.
- `score` output 8 — current score.
- `led_out` output `NUM_CH` — steady LED drive.
- `led_flash_out` output `NUM_CH` — flashing LED drive.
- `hit_pulse` output 1 — one-cycle pulse on a correct press.
- `miss_pulse` output 1 — one-cycle pulse on a wrong key, early press or timeout.
- `last_rt` output 32 — reaction time of the last hit, in cycles (see Configuration).

## Operation
- States: IDLE, WAIT, ACTIVE, RESULT.
- Reset values: state IDLE; every output 0; counters 0.
- IDLE:
  - LEDs off.
  - If `run_enable` is high → WAIT next cycle.
- Entering WAIT:
  - Sample `sel = rnd[1:0]`.
  - Load counter with `OFF_BASE << sel` (1×, 2×, 4× or 8× the base).
- WAIT:
  - LEDs off; counter decrements.
  - Any `key_edge` bit → early press: `miss_pulse`, score −1 (floored at 0), → RESULT(miss).
  - Otherwise, when counter == 1 → ACTIVE.
- Entering ACTIVE:
  - Channel `ch = rnd[15:8] % NUM_CH`.
  - Latch window `T = (score ≥ RAMP_SCORE) ? MIN_ACTIVE : MIN_ACTIVE + (MAX_ACTIVE−MIN_ACTIVE)*(RAMP_SCORE−score)/RAMP_SCORE`.
  - Compute `T` with a 64-bit intermediate and truncating division.
  - Load counter = `T`; `led_out` = one-hot(`ch`).
- ACTIVE, priority order each cycle:
  1. `key_edge` == one-hot(`ch`) exactly → hit: score +1 (saturates at `SCORE_MAX`), `hit_pulse`.
  2. Any other nonzero `key_edge`, including the correct key together with others → miss: score −1 (floored at 0), `miss_pulse`.
  3. Counter == 1 → timeout: miss handling as in 2.
  4. Otherwise counter decrements.
  - Cases 1–3 go → RESULT.
- RESULT, lasting `RESULT_CYCLES` cycles:
  - On a hit: `led_out` holds one-hot(`ch`).
  - On a miss: `led_out` = 0; `led_flash_out` is all-ones and all-zeros alternately, toggling every `FLASH_HALF` cycles and starting at all-ones.
  - On exit: both LED outputs are 0 → WAIT.
- `run_enable` low, in any state: next cycle state IDLE, score 0, LEDs 0, pulses 0. `last_rt` is held.
- `rst` asserted mid-game: everything returns to its reset value immediately.

## Timing
- All outputs are registered.
- `led_out` rises in the first ACTIVE cycle.
- The window is exactly `T` cycles. A key edge in any of those cycles is judged; an edge in the cycle after the last is seen in RESULT and ignored.
- `hit_pulse` / `miss_pulse` are high in the first RESULT cycle. `score` updates in the same cycle.
- WAIT lasts exactly `OFF_BASE << sel` cycles unless an early press occurs.
- `key_edge` in IDLE or RESULT is ignored.

## Configuration
- `REACTION_RT_MEASURE_EN` defined:
  - A 32-bit counter counts from 1 in the first ACTIVE cycle.
  - On a hit, `last_rt` ← count, held until the next hit or `rst`.
- Not defined: `last_rt` is tied to 0 and no counter is built.

## Test plan
Parameters for every scenario: `NUM_CH`=4, `SCORE_MAX`=5, `RAMP_SCORE`=3, `MIN_ACTIVE`=10, `MAX_ACTIVE`=40, `OFF_BASE`=8, `RESULT_CYCLES`=4, `FLASH_HALF`=2.

- Hit timing: `rst` pulse, `run_enable`=1, `rnd[1:0]`=2, `rnd[15:8]`=6. Expect WAIT of 32 cycles, then `led_out`=4'b0100. Press `key_edge`=4'b0100 in the 5th ACTIVE cycle → `hit_pulse`, score 1, `last_rt`=5 (with macro).
- Timeout and floor: score 0, no key. ACTIVE lasts exactly 40 cycles → `miss_pulse`, score stays 0. `led_flash_out` reads F,F,0,0 over RESULT.
- Window ramp: drive score to 1, then 3. Expect next windows of 30 and 10 cycles, and 10 again at score 5.
- Key conflicts: press in WAIT → miss, back to WAIT after 4 cycles. Correct key plus another key in ACTIVE → miss. Six hits → score saturates at 5.
- Reset and disable: assert `rst` mid-ACTIVE → all outputs 0 in the same cycle. Drop `run_enable` in RESULT → IDLE and score 0 next cycle.

Source files
------------

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: random off delay, one lit channel, scoring with a shrinking window.
// Optional reaction-time measurement is built when REACTION_RT_MEASURE_EN is defined.
module reaction_game_ctrl #(
   parameter int unsigned NUM_CH        = 2,
   parameter int unsigned SCORE_MAX     = 99,
   parameter int unsigned RAMP_SCORE    = 33,
   parameter int unsigned MIN_ACTIVE    = 15000000,
   parameter int unsigned MAX_ACTIVE    = 75000000,
   parameter int unsigned OFF_BASE      = 12500000,
   parameter int unsigned RESULT_CYCLES = 25000000,
   parameter int unsigned FLASH_HALF    = 2500000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run_enable,
   input  logic [31:0]       rnd,
   input  logic [NUM_CH-1:0] key_edge,
   output logic [7:0]        score,
   output logic [NUM_CH-1:0] led_out,
   output logic [NUM_CH-1:0] led_flash_out,
   output logic              hit_pulse,
   output logic              miss_pulse,
   output logic [31:0]       last_rt
);
   localparam int unsigned CNT_W   = 32;
   localparam int unsigned SCORE_W = 8;
   localparam logic [63:0] MIN64   = 64'(MIN_ACTIVE);
   localparam logic [63:0] SPAN64  = 64'(MAX_ACTIVE - MIN_ACTIVE);
   localparam logic [63:0] RAMP64  = 64'(RAMP_SCORE);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACTIVE, S_RESULT} state_t;

   state_t              state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [CNT_W-1:0]    fcnt, fcnt_d;
   logic [SCORE_W-1:0]  score_d;
   logic [NUM_CH-1:0]   led_d, flash_d;
   logic                hit_d, miss_d;

   logic [CNT_W-1:0]    wait_len_c, window_c;
   logic [NUM_CH-1:0]   target_c;
   logic [SCORE_W-1:0]  score_inc_c, score_dec_c;
   logic [63:0]         ramp_c;
   logic [7:0]          ch_c;
   logic                unused_rnd;

   assign unused_rnd  = ^{rnd[31:16], rnd[7:2]};
   assign wait_len_c  = CNT_W'(OFF_BASE) << rnd[1:0];
   assign ch_c        = 8'(rnd[15:8] % 8'(NUM_CH));
   assign target_c    = NUM_CH'(1) << ch_c;
   // Linear window ramp; the ramp term is only used while score is below RAMP_SCORE
   assign ramp_c      = MIN64 + (SPAN64 * (RAMP64 - 64'(score))) / RAMP64;
   assign window_c    = (64'(score) >= RAMP64) ? CNT_W'(MIN_ACTIVE) : CNT_W'(ramp_c);
   assign score_inc_c = (score >= SCORE_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : score + SCORE_W'(1);
   assign score_dec_c = (score == '0) ? '0 : score - SCORE_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= S_IDLE;
         cnt           <= '0;
         fcnt          <= '0;
         score         <= '0;
         led_out       <= '0;
         led_flash_out <= '0;
         hit_pulse     <= 1'b0;
         miss_pulse    <= 1'b0;
      end else begin
         state         <= state_d;
         cnt           <= cnt_d;
         fcnt          <= fcnt_d;
         score         <= score_d;
         led_out       <= led_d;
         led_flash_out <= flash_d;
         hit_pulse     <= hit_d;
         miss_pulse    <= miss_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      fcnt_d  = fcnt;
      score_d = score;
      led_d   = led_out;
      flash_d = led_flash_out;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      case (state)
         S_IDLE: begin
            led_d   = '0;
            flash_d = '0;
            if (run_enable) begin
               state_d = S_WAIT;
               cnt_d   = wait_len_c;
            end
         end
         S_WAIT: begin
            if (|key_edge) begin
               miss_d = 1'b1;
            end else if (cnt == CNT_W'(1)) begin
               state_d = S_ACTIVE;
               cnt_d   = window_c;
               led_d   = target_c;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         S_ACTIVE: begin
            if (key_edge == led_out) begin
               hit_d   = 1'b1;
               score_d = score_inc_c;
               state_d = S_RESULT;
               cnt_d   = CNT_W'(RESULT_CYCLES);
            end else if ((|key_edge) || (cnt == CNT_W'(1))) begin
               miss_d = 1'b1;
            end else begin
               cnt_d = cnt - CNT_W'(1);
            end
         end
         S_RESULT: begin
            if (cnt == CNT_W'(1)) begin
               state_d = S_WAIT;
               cnt_d   = wait_len_c;
               led_d   = '0;
               flash_d = '0;
            end else begin
               cnt_d = cnt - CNT_W'(1);
               // A miss result is the only one with the steady LEDs dark
               if (led_out == '0) begin
                  if (fcnt == CNT_W'(1)) begin
                     flash_d = ~led_flash_out;
                     fcnt_d  = CNT_W'(FLASH_HALF);
                  end else begin
                     fcnt_d = fcnt - CNT_W'(1);
                  end
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (miss_d) begin
         score_d = score_dec_c;
         state_d = S_RESULT;
         cnt_d   = CNT_W'(RESULT_CYCLES);
         fcnt_d  = CNT_W'(FLASH_HALF);
         led_d   = '0;
         flash_d = '1;
      end

      if (!run_enable) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         fcnt_d  = '0;
         score_d = '0;
         led_d   = '0;
         flash_d = '0;
         hit_d   = 1'b0;
         miss_d  = 1'b0;
      end
   end

`ifdef REACTION_RT_MEASURE_EN
   logic [31:0] rt_cnt;

   // Count starts at 1 in the first ACTIVE cycle and is captured on a hit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rt_cnt  <= '0;
         last_rt <= '0;
      end else begin
         if (state == S_WAIT && state_d == S_ACTIVE) begin
            rt_cnt <= 32'd1;
         end else if (state == S_ACTIVE) begin
            rt_cnt <= rt_cnt + 32'd1;
         end
         if (hit_d) begin
            last_rt <= rt_cnt;
         end
      end
   end
`else
   assign last_rt = '0;
`endif

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed self-checking bench for reaction_game_ctrl with small timing parameters.
module tb_reaction_game_ctrl;
   logic        clk = 1'b0;
   logic        rst;
   logic        run_enable;
   logic [31:0] rnd;
   logic [3:0]  key_edge;
   logic [7:0]  score;
   logic [3:0]  led_out;
   logic [3:0]  led_flash_out;
   logic        hit_pulse;
   logic        miss_pulse;
   logic [31:0] last_rt;

   int n_assert = 0;
   int n_fail   = 0;

`ifdef REACTION_RT_MEASURE_EN
   localparam logic [31:0] RT_FIRST = 32'd5;
   localparam logic [31:0] RT_LAST  = 32'd1;
`else
   localparam logic [31:0] RT_FIRST = 32'd0;
   localparam logic [31:0] RT_LAST  = 32'd0;
`endif

   always #5 clk = ~clk;

   reaction_game_ctrl #(
      .NUM_CH(4), .SCORE_MAX(5), .RAMP_SCORE(3), .MIN_ACTIVE(10), .MAX_ACTIVE(40),
      .OFF_BASE(8), .RESULT_CYCLES(4), .FLASH_HALF(2)
   ) dut (
      .clk(clk), .rst(rst), .run_enable(run_enable), .rnd(rnd), .key_edge(key_edge),
      .score(score), .led_out(led_out), .led_flash_out(led_flash_out),
      .hit_pulse(hit_pulse), .miss_pulse(miss_pulse), .last_rt(last_rt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic press(input logic [3:0] k);
      key_edge = k;
      @(negedge clk);
      key_edge = '0;
   endtask

   // Negedges until the steady LEDs light
   task automatic until_led(output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (led_out == '0 && n < 300);
   endtask

   // Return at the first ACTIVE cycle of the next round
   task automatic wait_active();
      int n;
      n = 0;
      while (led_out != '0 && n < 300) begin
         @(negedge clk);
         n++;
      end
      until_led(n);
      check("active_reached", 32'(led_out != '0), 32'd1);
   endtask

   // Called in the first ACTIVE cycle; returns window length + 1
   task automatic active_len(output int n);
      n = 1;
      while (!hit_pulse && !miss_pulse && n < 300) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic hit_round(input int exp_score);
      wait_active();
      check("hit_led", 32'(led_out), 32'h4);
      press(4'b0100);
      check("hit_pulse", 32'(hit_pulse), 32'd1);
      check("hit_score", 32'(score), 32'(exp_score));
   endtask

   task automatic timeout_round(input int exp_t, input int exp_score);
      int n;
      wait_active();
      active_len(n);
      check("window_len", 32'(n - 1), 32'(exp_t));
      check("timeout_miss", 32'(miss_pulse), 32'd1);
      check("timeout_score", 32'(score), 32'(exp_score));
   endtask

   initial begin
      int n;
      rst = 1'b1; run_enable = 1'b0; rnd = '0; key_edge = '0;
      repeat (3) @(negedge clk);
      check("rst_score", 32'(score), 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_flash", 32'(led_flash_out), 32'd0);
      check("rst_hit", 32'(hit_pulse), 32'd0);
      check("rst_miss", 32'(miss_pulse), 32'd0);
      check("rst_last_rt", last_rt, 32'd0);

      // Hit timing: sel=2 gives a 32-cycle WAIT, channel 6%4=2
      rst = 1'b0; rnd = 32'h0000_0602; run_enable = 1'b1;
      until_led(n);
      check("wait_len_sel2", 32'(n), 32'd33);
      check("led_onehot", 32'(led_out), 32'h4);
      repeat (4) @(negedge clk);
      check("no_pulse_active", 32'(hit_pulse | miss_pulse), 32'd0);
      press(4'b0100);
      check("hit1_pulse", 32'(hit_pulse), 32'd1);
      check("hit1_miss", 32'(miss_pulse), 32'd0);
      check("hit1_score", 32'(score), 32'd1);
      check("hit1_last_rt", last_rt, RT_FIRST);
      check("hit1_led_hold", 32'(led_out), 32'h4);
      check("hit1_flash", 32'(led_flash_out), 32'd0);
      @(negedge clk);
      check("hit1_pulse_end", 32'(hit_pulse), 32'd0);

      // Timeout at score 0: 40-cycle window, score floors at 0, flash F,F,0,0
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; rnd = 32'h0000_0100;
      until_led(n);
      check("wait_len_sel0", 32'(n), 32'd9);
      check("led_ch1", 32'(led_out), 32'h2);
      active_len(n);
      check("window_score0", 32'(n - 1), 32'd40);
      check("timeout_pulse", 32'(miss_pulse), 32'd1);
      check("timeout_floor", 32'(score), 32'd0);
      check("timeout_led", 32'(led_out), 32'd0);
      check("flash_1", 32'(led_flash_out), 32'hF);
      rnd = 32'h0000_0600;
      @(negedge clk);
      check("flash_2", 32'(led_flash_out), 32'hF);
      check("miss_pulse_end", 32'(miss_pulse), 32'd0);
      @(negedge clk);
      check("flash_3", 32'(led_flash_out), 32'h0);
      @(negedge clk);
      check("flash_4", 32'(led_flash_out), 32'h0);
      @(negedge clk);
      check("flash_exit", 32'(led_flash_out | led_out), 32'h0);

      // Window ramp: 30 at score 1, 10 at score 3 and at score 5
      hit_round(1);
      timeout_round(30, 0);
      hit_round(1);
      hit_round(2);
      hit_round(3);
      timeout_round(10, 2);
      hit_round(3);
      hit_round(4);
      hit_round(5);
      timeout_round(10, 4);

      // Early press in WAIT, then RESULT of 4 plus WAIT of 8
      repeat (6) @(negedge clk);
      check("wait_dark", 32'(led_out), 32'd0);
      press(4'b0001);
      check("early_miss", 32'(miss_pulse), 32'd1);
      check("early_score", 32'(score), 32'd3);
      check("early_flash", 32'(led_flash_out), 32'hF);
      until_led(n);
      check("early_to_active", 32'(n), 32'd12);
      press(4'b0101);
      check("multi_key_miss", 32'(miss_pulse), 32'd1);
      check("multi_key_nohit", 32'(hit_pulse), 32'd0);
      check("multi_key_score", 32'(score), 32'd2);

      // Saturation: 2 -> 3,4,5,5,5,5
      for (int i = 0; i < 6; i++) begin
         hit_round((i + 3 > 5) ? 5 : i + 3);
      end

      // Asynchronous reset mid-ACTIVE
      wait_active();
      repeat (2) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("async_rst_led", 32'(led_out), 32'd0);
      check("async_rst_score", 32'(score), 32'd0);
      check("async_rst_flash", 32'(led_flash_out), 32'd0);
      check("async_rst_rt", last_rt, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Disable during RESULT
      hit_round(1);
      check("hit_last_rt", last_rt, RT_LAST);
      run_enable = 1'b0;
      @(negedge clk);
      check("dis_score", 32'(score), 32'd0);
      check("dis_led", 32'(led_out), 32'd0);
      check("dis_hit", 32'(hit_pulse), 32'd0);
      check("dis_last_rt_held", last_rt, RT_LAST);
      press(4'b0100);
      check("idle_key_ignored", 32'(miss_pulse | hit_pulse), 32'd0);
      repeat (10) @(negedge clk);
      check("idle_dark", 32'(led_out | led_flash_out), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
